// File: rtl/darkriscv_arb_pkg.sv
// ============================================================
// darkriscv_arb_pkg - shared types/constants for the dbus arbiter
// rev 1.0
// ============================================================
`default_nettype none

package darkriscv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CORE_ACC = 2'd1,
    ST_DMA_ACC  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_t;

  localparam logic [2:0]  DLEN_B       = 3'd1;
  localparam logic [2:0]  DLEN_H       = 3'd2;
  localparam logic [2:0]  DLEN_W       = 3'd4;
  localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/darkriscv_arb_wdog.sv
// ============================================================
// darkriscv_arb_wdog - wait-state watchdog, expires at TIMEOUT
// rev 1.0
// ============================================================
`default_nettype none

module darkriscv_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = i_en && (r_cnt == 8'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/darkriscv_dbus_arbiter.sv
// ============================================================
// darkriscv_dbus_arbiter - shares the data-memory port between core and DMA
// rev 1.0
// ============================================================
`default_nettype none

module darkriscv_dbus_arbiter
  import darkriscv_arb_pkg::*;
#(
  parameter int MAX_CORE_STREAK = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic        i_clk,
  input  logic        i_res,
  input  logic [31:0] i_core_daddr,
  input  logic [31:0] i_core_datao,
  input  logic [2:0]  i_core_dlen,
  input  logic        i_core_drd,
  input  logic        i_core_dwr,
  output logic [31:0] o_core_datai,
  output logic        o_core_hlt,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  input  logic [2:0]  i_dma_dlen,
  output logic [31:0] o_dma_rdata,
  output logic        o_dma_ack,
  output logic        o_dma_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_mem_dlen,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic        o_tmo_pulse
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  owner_t      w_owner;
  logic [3:0]  r_streak;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [2:0]  r_mem_dlen;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [31:0] r_dma_rdata;
  logic        r_dma_ack;
  logic        r_dma_err;

  logic w_core_rq;
  logic w_dma_pend;
  logic w_idle;
  logic w_in_acc;
  logic w_expire;
  logic w_timeout;
  logic w_done;
  logic w_core_grant;
  logic w_dma_grant;

  assign w_core_rq = i_core_drd | i_core_dwr;
  // The requester still holds dma_req during the ack cycle; masking it stops a duplicate grant.
  assign w_dma_pend = i_dma_req && !r_dma_ack;
  assign w_idle     = (r_state == ST_IDLE);
  assign w_in_acc   = !w_idle;
  assign w_owner    = (r_state == ST_DMA_ACC) ? OWN_DMA : OWN_CORE;
  assign w_timeout  = w_expire && !i_mem_ready;
  assign w_done     = w_in_acc && (i_mem_ready || w_expire);

  assign w_core_grant = w_idle && w_core_rq && (!w_dma_pend || (r_streak < 4'(MAX_CORE_STREAK)));
  assign w_dma_grant  = w_idle && !w_core_grant && w_dma_pend;

  darkriscv_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_res),
    .i_clr    (w_idle),
    .i_en     (w_in_acc),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_core_grant) begin
          w_state_nxt = ST_CORE_ACC;
        end else if (w_dma_grant) begin
          w_state_nxt = ST_DMA_ACC;
        end
      end
      ST_CORE_ACC, ST_DMA_ACC: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_dlen  <= 3'd0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_dma_rdata <= 32'd0;
      r_dma_ack   <= 1'b0;
      r_dma_err   <= 1'b0;
      r_streak    <= 4'd0;
    end else begin
      r_dma_ack <= 1'b0;
      r_dma_err <= 1'b0;
      if (w_core_grant) begin
        r_mem_addr  <= i_core_daddr;
        r_mem_wdata <= i_core_datao;
        r_mem_dlen  <= i_core_dlen;
        r_mem_rd    <= !i_core_dwr;
        r_mem_wr    <= i_core_dwr;
      end else if (w_dma_grant) begin
        r_mem_addr  <= i_dma_addr;
        r_mem_wdata <= i_dma_wdata;
        r_mem_dlen  <= i_dma_dlen;
        r_mem_rd    <= !i_dma_we;
        r_mem_wr    <= i_dma_we;
      end else if (w_done) begin
        r_mem_rd <= 1'b0;
        r_mem_wr <= 1'b0;
        if (w_owner == OWN_DMA) begin
          r_dma_ack   <= 1'b1;
          r_dma_err   <= w_timeout;
          r_dma_rdata <= w_timeout ? BUS_ERR_DATA : i_mem_rdata;
        end
      end

      if (!w_dma_pend || w_dma_grant) begin
        r_streak <= 4'd0;
      end else if (w_core_grant && (r_streak != 4'hF)) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  always_comb begin
    o_core_datai = 32'd0;
    if ((r_state == ST_CORE_ACC) && w_done) begin
      o_core_datai = w_timeout ? BUS_ERR_DATA : i_mem_rdata;
    end
  end

  assign o_core_hlt  = w_core_rq && !((r_state == ST_CORE_ACC) && w_done);
  assign o_tmo_pulse = w_timeout;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_dlen  = r_mem_dlen;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_wr    = r_mem_wr;
  assign o_dma_rdata = r_dma_rdata;
  assign o_dma_ack   = r_dma_ack;
  assign o_dma_err   = r_dma_err;

endmodule

`default_nettype wire
